seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder_if.sv | 34 +++
 rtl/seg_scan_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder_if.sv
// Bundle between a 7-segment scan source/frame consumer and the decoder.
// The scan lines and the frame handshake share one interface; clk/rst_n stay separate.
interface seg_scan_decoder_if;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic [31:0] frame_data;
  logic [7:0]  frame_err;
  logic [7:0]  frame_dp;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  modport master (
    output anode,
    output cathode,
    output frame_ready,
    input  frame_data,
    input  frame_err,
    input  frame_dp,
    input  frame_valid,
    input  overrun
  );

  modport slave (
    input  anode,
    input  cathode,
    input  frame_ready,
    output frame_data,
    output frame_err,
    output frame_dp,
    output frame_valid,
    output overrun
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 7-segment scan into 8-nibble frames: a digit is captured after STABLE_CYCLES identical synced samples.
// Frames are held under valid/ready; a frame completed while the previous one is still unaccepted is dropped with an overrun pulse.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  typedef enum logic {
    COLLECT,
    PRESENT
  } state_t;

  logic [7:0]  anode_s1, anode_s2, cathode_s1, cathode_s2;
  logic [7:0]  anode_prev, cathode_prev;
  logic [7:0]  stable_cnt, stable_cnt_nxt;
  logic        sel_ok, pair_same, capture;
  logic [2:0]  digit_idx;
  logic [4:0]  glyph;
  logic [7:0]  seen, seen_nxt;
  logic [31:0] col_data, col_data_nxt;
  logic [7:0]  col_err, col_err_nxt;
  logic [7:0]  col_dp, col_dp_nxt;
  logic        frame_done;
  logic        accept;
  state_t      state;
  logic [31:0] frame_data;
  logic [7:0]  frame_err, frame_dp;
  logic        frame_valid, overrun;

  // Returns {err, nibble}; anything off the glyph table (blank included) is nibble 0 with err.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_s1     <= 8'hFF;
      anode_s2     <= 8'hFF;
      cathode_s1   <= 8'hFF;
      cathode_s2   <= 8'hFF;
      anode_prev   <= 8'hFF;
      cathode_prev <= 8'hFF;
    end else begin
      anode_s1     <= bus.anode;
      anode_s2     <= anode_s1;
      cathode_s1   <= bus.cathode;
      cathode_s2   <= cathode_s1;
      anode_prev   <= anode_s2;
      cathode_prev <= cathode_s2;
    end
  end

  // Capture fires on the single cycle the counter steps to STABLE_CYCLES-1; saturation blocks recapture.
  always_comb begin
    sel_ok    = $onehot(~anode_s2);
    pair_same = (anode_s2 == anode_prev) && (cathode_s2 == cathode_prev);
    if (!sel_ok || !pair_same) begin
      stable_cnt_nxt = 8'd0;
    end else if (stable_cnt < CNT_MAX) begin
      stable_cnt_nxt = stable_cnt + 8'd1;
    end else begin
      stable_cnt_nxt = stable_cnt;
    end
    capture = sel_ok && pair_same && (stable_cnt_nxt == CNT_CAP);
  end

  always_comb begin
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!anode_s2[i]) begin
        digit_idx = 3'(i);
      end
    end
    glyph = decode_glyph(cathode_s2[6:0]);
  end

  always_comb begin
    seen_nxt     = seen;
    col_data_nxt = col_data;
    col_err_nxt  = col_err;
    col_dp_nxt   = col_dp;
    if (capture) begin
      seen_nxt[digit_idx]                     = 1'b1;
      col_data_nxt[{digit_idx, 2'b00} +: 4]   = glyph[3:0];
      col_err_nxt[digit_idx]                  = glyph[4];
      col_dp_nxt[digit_idx]                   = ~cathode_s2[7];
    end
    frame_done = capture && (seen_nxt == 8'hFF);
    accept     = frame_valid && bus.frame_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= 8'd0;
      seen       <= 8'd0;
      col_data   <= 32'd0;
      col_err    <= 8'd0;
      col_dp     <= 8'd0;
    end else begin
      stable_cnt <= stable_cnt_nxt;
      seen       <= frame_done ? 8'd0 : seen_nxt;
      col_data   <= col_data_nxt;
      col_err    <= col_err_nxt;
      col_dp     <= col_dp_nxt;
    end
  end

  // Loading from the *_nxt values lets the completing digit land in the same frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      frame_data  <= 32'd0;
      frame_err   <= 8'd0;
      frame_dp    <= 8'd0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        COLLECT: begin
          if (frame_done) begin
            frame_data  <= col_data_nxt;
            frame_err   <= col_err_nxt;
            frame_dp    <= col_dp_nxt;
            frame_valid <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (frame_done && accept) begin
            frame_data  <= col_data_nxt;
            frame_err   <= col_err_nxt;
            frame_dp    <= col_dp_nxt;
          end else if (frame_done) begin
            overrun     <= 1'b1;
          end else if (accept) begin
            frame_valid <= 1'b0;
            state       <= COLLECT;
          end
        end
      endcase
    end
  end

  assign bus.frame_data  = frame_data;
  assign bus.frame_err   = frame_err;
  assign bus.frame_dp    = frame_dp;
  assign bus.frame_valid = frame_valid;
  assign bus.overrun     = overrun;

endmodule
